// File: rtl/number_uart_tx_pkg.sv
// Shared types and constants for the multi-byte UART number transmitter.
package number_uart_tx_pkg;

  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned MAX_BYTES  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/number_uart_tx_baud_tick.sv
// Bit-period timer: one-cycle tick on the last clock of every CLKS_PER_BIT period.
module number_uart_tx_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/number_uart_tx.sv
// Sends the NUM_BYTES low bytes of a captured 256-bit number as back-to-back 8N1 frames.
module number_uart_tx
  import number_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned NUM_BYTES    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [8*MAX_BYTES-1:0]   number,
  output logic                     tx,
  output logic                     busy,
  output logic                     done,
  output logic [4:0]               byte_idx
);

  localparam logic [4:0] LAST_BYTE = 5'(NUM_BYTES - 1);

  uart_state_t            state;
  logic [2:0]             bit_idx;
  logic [8*MAX_BYTES-1:0] shadow;
  logic [7:0]             cur_byte;
  logic                   tick;

  number_uart_tx_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk  (clk),
    .reset(reset),
    .clear(state == IDLE),
    .tick (tick)
  );

  // Shadow is deliberately unreset: only meaningful once a burst has been captured.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      shadow <= number;
    end
  end

  assign cur_byte = shadow[{byte_idx, 3'b000} +: 8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      byte_idx <= '0;
      bit_idx  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= START;
            tx       <= 1'b0;
            busy     <= 1'b1;
            byte_idx <= '0;
            bit_idx  <= '0;
          end
        end
        START: begin
          if (tick) begin
            state   <= DATA;
            bit_idx <= '0;
            tx      <= cur_byte[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= cur_byte[bit_idx + 3'd1];
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (byte_idx < LAST_BYTE) begin
              byte_idx <= byte_idx + 5'd1;
              state    <= START;
              tx       <= 1'b0;
            end else begin
              state    <= IDLE;
              byte_idx <= '0;
              busy     <= 1'b0;
              done     <= 1'b1;
              tx       <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_number_uart_tx.sv
// Directed bench for number_uart_tx: frame vectors table plus burst/abort/back-to-back sequences.
module tb_number_uart_tx;

  localparam int C = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_a, start_b;
  logic [255:0] number_a, number_b;
  logic         tx_a, busy_a, done_a, tx_b, busy_b, done_b;
  logic [4:0]   byte_idx_a, byte_idx_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  number_uart_tx #(.CLKS_PER_BIT(4), .NUM_BYTES(32)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .number(number_a),
    .tx(tx_a), .busy(busy_a), .done(done_a), .byte_idx(byte_idx_a)
  );

  number_uart_tx #(.CLKS_PER_BIT(2), .NUM_BYTES(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .number(number_b),
    .tx(tx_b), .busy(busy_b), .done(done_b), .byte_idx(byte_idx_b)
  );

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [9:0] f0;
    logic [9:0] f1;
  } vec_t;

  vec_t         vecs[4];
  logic [19:0]  bits;
  logic [255:0] pat, dec;
  int           idx_err, busy_cyc, dones, ferr, found, done_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Returns at the negedge just after the accepting edge.
  task automatic pulse_start_a(input logic [255:0] num);
    @(negedge clk);
    number_a = num;
    start_a  = 1'b1;
    @(negedge clk);
    start_a  = 1'b0;
  endtask

  // Follows a running burst from its first cycle; exits on the first cycle with busy low.
  task automatic run_burst(input int inject_at, input logic [255:0] inj,
                           output int bcyc, output int nd, output logic [255:0] d,
                           output int fe);
    int j, f, b;
    bcyc = 0; nd = 0; d = '0; fe = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) @(negedge clk);
      if (c == inject_at) begin
        start_a  = 1'b1;
        number_a = inj;
      end else begin
        start_a = 1'b0;
      end
      if (done_a) nd++;
      if (!busy_a) break;
      bcyc++;
      if (c % C == 1) begin
        j = c / C;
        f = j / 10;
        b = j % 10;
        if (f < 32) begin
          if (b == 0) begin
            if (tx_a !== 1'b0) fe++;
          end else if (b == 9) begin
            if (tx_a !== 1'b1) fe++;
          end else begin
            d[8*f + b - 1] = tx_a;
          end
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'hA5, 8'h00, 10'b1101001010, 10'b1000000000};
    vecs[1] = '{8'hFF, 8'h01, 10'b1111111110, 10'b1000000010};
    vecs[2] = '{8'h80, 8'h3C, 10'b1100000000, 10'b1001111000};
    vecs[3] = '{8'h5A, 8'hC3, 10'b1010110100, 10'b1110000110};

    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; number_a = '0; number_b = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_tx_a", tx_a, 1);
    check("reset_busy_a", busy_a, 0);
    check("reset_done_a", done_a, 0);
    check("reset_idx_a", byte_idx_a, 0);
    check("reset_tx_b", tx_b, 1);
    check("reset_busy_b", busy_b, 0);
    reset = 1'b0;

    // Frame table: bytes 0 and 1 sampled mid-bit; each entry ends with a reset abort.
    for (int i = 0; i < 4; i++) begin
      do_reset();
      pulse_start_a({240'h0, vecs[i].b1, vecs[i].b0});
      idx_err = 0;
      for (int j = 0; j < 20; j++) begin
        repeat ((j == 0) ? 1 : C) @(negedge clk);
        bits[j] = tx_a;
        if (j < 10 && byte_idx_a !== 5'd0) idx_err++;
        if (j >= 10 && byte_idx_a !== 5'd1) idx_err++;
      end
      check($sformatf("vec%0d_frame0", i), bits[9:0], vecs[i].f0);
      check($sformatf("vec%0d_frame1", i), bits[19:10], vecs[i].f1);
      check($sformatf("vec%0d_byte_idx", i), idx_err, 0);
    end

    // Full zero burst: length, single done, all bytes zero.
    do_reset();
    pulse_start_a('0);
    run_burst(-1, '0, busy_cyc, dones, dec, ferr);
    check("zero_busy_cycles", busy_cyc, 1280);
    check("zero_done_pulses", dones, 1);
    check("zero_bytes", {31'b0, |dec}, 0);
    check("zero_framing", ferr, 0);
    check("zero_idx_idle", byte_idx_a, 0);

    // Start in the done cycle: new burst begins on that edge.
    for (int k = 0; k < 32; k++) pat[8*k +: 8] = 8'(k * 37 + 5);
    number_a = pat;
    start_a  = 1'b1;
    @(negedge clk);
    start_a  = 1'b0;
    check("b2b_tx_low", tx_a, 0);
    check("b2b_busy", busy_a, 1);
    check("b2b_done_cleared", done_a, 0);

    // Restart attempt and number change 100 cycles in must be ignored.
    run_burst(100, ~pat, busy_cyc, dones, dec, ferr);
    check("ignore_busy_cycles", busy_cyc, 1280);
    check("ignore_done_pulses", dones, 1);
    check("ignore_bytes_match", {31'b0, dec == pat}, 1);
    check("ignore_framing", ferr, 0);
    @(negedge clk);
    check("done_one_cycle", done_a, 0);
    check("no_restart", busy_a, 0);

    // Reset mid DATA of byte 5 (byte 5 = 8'hBE, bit 0 = 0).
    pulse_start_a(pat);
    found = 0;
    for (int c = 0; c < 400 && found == 0; c++) begin
      @(negedge clk);
      if (byte_idx_a == 5'd5) found = 1;
    end
    check("reach_byte5", found, 1);
    repeat (5) @(negedge clk);
    check("abort_pre_tx", tx_a, 0);
    check("abort_pre_idx", byte_idx_a, 5);
    #2 reset = 1'b1;
    #1;
    check("abort_tx", tx_a, 1);
    check("abort_busy", busy_a, 0);
    check("abort_idx", byte_idx_a, 0);
    done_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done_a) done_seen++;
    end
    reset = 1'b0;
    @(negedge clk);
    if (done_a) done_seen++;
    check("abort_no_done", done_seen, 0);
    pulse_start_a(pat);
    for (int j = 0; j < 10; j++) begin
      repeat ((j == 0) ? 1 : C) @(negedge clk);
      bits[j] = tx_a;
    end
    check("after_abort_frame0", bits[9:0], 10'b1000001010);
    check("after_abort_idx", byte_idx_a, 0);

    // Single-byte, 2 clocks per bit instance.
    @(negedge clk);
    number_b = 256'h01;
    start_b  = 1'b1;
    @(negedge clk);
    start_b  = 1'b0;
    idx_err  = 0;
    for (int s = 0; s < 20; s++) begin
      if (s > 0) @(negedge clk);
      bits[s] = tx_b;
      if (!busy_b) idx_err++;
    end
    check("nb1_samples", bits, 20'hC000C);
    check("nb1_busy_throughout", idx_err, 0);
    @(negedge clk);
    check("nb1_busy_end", busy_b, 0);
    check("nb1_done", done_b, 1);
    check("nb1_tx_idle", tx_b, 1);
    @(negedge clk);
    check("nb1_done_cleared", done_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/number_uart_tx.md
NUMBER_UART_TX -- requirements
Module: number_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clk cycles per UART bit period; legal range 2..65535.
REQ-002 Parameter NUM_BYTES, default 32, number of bytes sent per frame burst; legal range 1..32.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request flag (button_handler_down output style).
REQ-006 number  input  256  value to transmit; byte k = number[8k+7:8k].
REQ-007 tx  output  1  UART line, 8N1, idle high.
REQ-008 busy  output  1  high while a burst is in progress.
REQ-009 done  output  1  one-cycle pulse at burst completion.
REQ-010 byte_idx  output  5  index of the byte currently on the line; feeds hex2digit_hex display.

Function
REQ-011 States: IDLE, START, DATA, STOP; state register is binary-encoded.
REQ-012 In IDLE: tx=1, busy=0, byte_idx=0.
REQ-013 start=1 in IDLE at edge k: capture number into a 256-bit shadow register, enter START; tx=0 and busy=1 from edge k onward.
REQ-014 start while busy is ignored; number changes after capture do not affect the burst.
REQ-015 Each bit holds tx for exactly CLKS_PER_BIT cycles, timed by a baud counter cleared on every bit boundary.
REQ-016 START: tx=0 for one bit period, then enter DATA with bit index 0.
REQ-017 DATA: tx = shadow[8*byte_idx + bit_idx], LSB first; after bit 7, enter STOP.
REQ-018 STOP: tx=1 for one bit period; then, if byte_idx < NUM_BYTES-1, increment byte_idx and enter START (no idle gap); otherwise enter IDLE.
REQ-019 Burst length: exactly 10*NUM_BYTES*CLKS_PER_BIT cycles from the first tx falling edge to the return to IDLE.
REQ-020 done=1 for exactly the one cycle following the STOP-to-IDLE edge, with busy=0 in that same cycle.
REQ-021 start asserted in the done cycle is accepted (state is IDLE); the new burst starts at that edge.
REQ-022 byte_idx wraps nowhere: it never exceeds NUM_BYTES-1 and returns to 0 on entering IDLE.
REQ-023 Baud counter width: ceil(log2(CLKS_PER_BIT)) bits; no overflow at the maximum parameter value.

Reset
REQ-024 reset=1 forces state=IDLE, tx=1, busy=0, done=0, byte_idx=0, counters=0 immediately, regardless of clk.
REQ-025 reset mid-burst aborts the burst without a done pulse; the next start after reset release begins at byte 0.
REQ-026 The shadow register is not reset; its contents are don't-care in IDLE.

Structure
REQ-027 The shared package holds the state enumeration, FRAME_BITS=10 and MAX_BYTES=32.
REQ-028 One sub-module, baud_tick: counter parameterised by CLKS_PER_BIT, with a clear input, emitting a one-cycle tick at the end of each bit period.
REQ-029 The top level instantiates baud_tick, the state machine, and the shadow register/byte mux only.

Verification (CLKS_PER_BIT=4, NUM_BYTES=32 unless stated)
REQ-030 number[7:0]=8'hA5, start pulse -> tx, sampled mid-bit: 0,1,0,1,0,0,1,0,1,1 for byte 0; byte_idx=0 throughout.
REQ-031 number=256'h0, start -> busy high for exactly 1280 cycles; one done pulse; all 32 frames read back as 8'h00.
REQ-032 Second start pulse 100 cycles into a burst, number changed at the same time -> no restart; decoded bytes equal the value captured at the first start.
REQ-033 start asserted in the done cycle -> tx falls on that edge; busy stays low for exactly that one cycle.
REQ-034 reset pulse at byte_idx=5, mid DATA -> tx=1, busy=0, done stays 0; a new start then sends byte 0 first.
REQ-035 NUM_BYTES=1, CLKS_PER_BIT=2, number[7:0]=8'h01 -> 20-cycle frame 0,1,0,0,0,0,0,0,0,1 (one bit per 2 cycles), then a done pulse.
